// File: rtl/output_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : output_accumulator
//  Description : Accumulates PE partial sums into an on-chip output feature
//                map (channel x height x width) through a 2-stage
//                read-modify-write pipeline with forwarding, then drains the
//                map through a valid/ready stream, zeroing entries as they
//                are read.
//                Optional feature macro: OUTPUT_ACC_SAT_EN
//                  defined   -> accumulation saturates at all-ones
//                  undefined -> accumulation wraps modulo 2**ACC_LEN
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef OUTPUT_CHANNEL
`define OUTPUT_CHANNEL 2
`endif
`ifndef OUTPUT_CHANNEL_LOG
`define OUTPUT_CHANNEL_LOG 2
`endif
`ifndef OUTPUT_HEIGHT_LOG
`define OUTPUT_HEIGHT_LOG 2
`endif
`ifndef OUTPUT_WIDTH_LOG
`define OUTPUT_WIDTH_LOG 2
`endif
`ifndef OUT_BIN_LEN
`define OUT_BIN_LEN 8
`endif

module output_accumulator #(
    parameter int OUTPUT_CHANNEL = `OUTPUT_CHANNEL,
    parameter int OUTPUT_HEIGHT  = 4,
    parameter int OUTPUT_WIDTH   = 4,
    parameter int OUT_BIN_LEN    = `OUT_BIN_LEN,
    parameter int ACC_LEN        = 24
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            w_en,
    input  logic [`OUTPUT_CHANNEL_LOG-1:0]  w_channel_index,
    input  logic [`OUTPUT_HEIGHT_LOG-1:0]   w_height_index,
    input  logic [`OUTPUT_WIDTH_LOG-1:0]    w_width_index,
    input  logic [OUT_BIN_LEN-1:0]          w_val,
    output logic                            acc_ready,
    output logic                            dropped,
    input  logic                            drain_start,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [`OUTPUT_CHANNEL_LOG-1:0]  rd_channel,
    output logic [`OUTPUT_HEIGHT_LOG-1:0]   rd_height,
    output logic [`OUTPUT_WIDTH_LOG-1:0]    rd_width,
    output logic [ACC_LEN-1:0]              rd_val,
    output logic                            rd_last,
    output logic                            drain_done
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int c_depth = OUTPUT_CHANNEL * OUTPUT_HEIGHT * OUTPUT_WIDTH;
    localparam int c_aw    = (c_depth > 1) ? $clog2(c_depth) : 1;
    localparam int c_cw    = `OUTPUT_CHANNEL_LOG;
    localparam int c_hw    = `OUTPUT_HEIGHT_LOG;
    localparam int c_ww    = `OUTPUT_WIDTH_LOG;

    localparam logic [c_aw-1:0] c_first = '0;
    localparam logic [c_aw-1:0] c_last  = c_aw'(c_depth - 1);

    // Controller states
    localparam logic [1:0] c_st_clear = 2'd0;
    localparam logic [1:0] c_st_accum = 2'd1;
    localparam logic [1:0] c_st_flush = 2'd2;
    localparam logic [1:0] c_st_drain = 2'd3;

    // FLUSH always lasts long enough for a write accepted in the
    // drain_start cycle to reach memory, giving a fixed start-up latency.
    localparam logic [1:0] c_flush_last = 2'd2;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [ACC_LEN-1:0]     r_mem [c_depth];

    logic [1:0]             r_state;
    logic [c_aw-1:0]        r_clr_cnt;
    logic [1:0]             r_flush_cnt;
    logic                   r_acc_ready;
    logic                   r_dropped;

    // Write pipeline: S1 holds the request, S2 holds the computed sum
    logic                   r_s1_vld;
    logic [c_aw-1:0]        r_s1_addr;
    logic [OUT_BIN_LEN-1:0] r_s1_val;
    logic                   r_s2_vld;
    logic [c_aw-1:0]        r_s2_addr;
    logic [ACC_LEN-1:0]     r_s2_sum;

    // Drain stream
    logic                   r_rd_valid;
    logic                   r_rd_last;
    logic                   r_drain_done;
    logic [ACC_LEN-1:0]     r_rd_val;
    logic [c_aw-1:0]        r_ptr;
    logic [c_cw-1:0]        r_rd_ch;
    logic [c_hw-1:0]        r_rd_h;
    logic [c_ww-1:0]        r_rd_w;

    // Combinational helpers
    logic                   w_in_range;
    logic                   w_accept;
    logic                   w_drop;
    logic [c_aw-1:0]        w_addr;
    logic [ACC_LEN-1:0]     w_operand;
    logic [ACC_LEN-1:0]     w_sum;
    logic                   w_rd_fire;
    logic [c_aw-1:0]        w_ptr_nxt;
    logic                   w_mem_we;
    logic [c_aw-1:0]        w_mem_waddr;
    logic [ACC_LEN-1:0]     w_mem_wdata;

    // ------------------------------------------------------------------
    // Write request decode: bounds check, flat address, accept/drop
    // ------------------------------------------------------------------
    always_comb begin
        w_in_range = (32'(w_channel_index) < 32'(OUTPUT_CHANNEL)) &&
                     (32'(w_height_index)  < 32'(OUTPUT_HEIGHT))  &&
                     (32'(w_width_index)   < 32'(OUTPUT_WIDTH));
        w_addr     = (c_aw'(w_channel_index) * c_aw'(OUTPUT_HEIGHT) +
                      c_aw'(w_height_index)) * c_aw'(OUTPUT_WIDTH) +
                     c_aw'(w_width_index);
        w_accept   = w_en && r_acc_ready && w_in_range;
        w_drop     = w_en && !(r_acc_ready && w_in_range);
    end

    // ------------------------------------------------------------------
    // Accumulate: operand comes from S2 when it targets the same entry,
    // since that result has not reached memory yet
    // ------------------------------------------------------------------
`ifdef OUTPUT_ACC_SAT_EN
    logic [ACC_LEN:0] w_sum_wide;
    always_comb begin
        w_operand  = (r_s2_vld && (r_s2_addr == r_s1_addr)) ? r_s2_sum
                                                            : r_mem[r_s1_addr];
        w_sum_wide = {1'b0, w_operand} + (ACC_LEN + 1)'(r_s1_val);
        w_sum      = w_sum_wide[ACC_LEN] ? {ACC_LEN{1'b1}} : w_sum_wide[ACC_LEN-1:0];
    end
`else
    always_comb begin
        w_operand = (r_s2_vld && (r_s2_addr == r_s1_addr)) ? r_s2_sum
                                                           : r_mem[r_s1_addr];
        w_sum     = w_operand + ACC_LEN'(r_s1_val);
    end
`endif

    assign w_rd_fire = r_rd_valid && rd_ready;
    assign w_ptr_nxt = r_ptr + 1'b1;

    // ------------------------------------------------------------------
    // Single memory write port: clear sweep, S2 commit or drain zeroing
    // (the controller guarantees these never overlap)
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = r_clr_cnt;
        w_mem_wdata = '0;
        if (r_state == c_st_clear) begin
            w_mem_we = 1'b1;
        end else if (r_s2_vld) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_s2_addr;
            w_mem_wdata = r_s2_sum;
        end else if ((r_state == c_st_drain) && w_rd_fire) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_ptr;
        end
    end

    // Memory array update; contents are rebuilt by CLEAR after reset
    always_ff @(posedge clock) begin
        if (!reset && w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Two-stage write pipeline registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_vld  <= 1'b0;
            r_s1_addr <= '0;
            r_s1_val  <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_addr <= '0;
            r_s2_sum  <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_addr <= w_addr;
                r_s1_val  <= w_val;
            end
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_addr <= r_s1_addr;
                r_s2_sum  <= w_sum;
            end
        end
    end

    // Controller: clear sweep, accumulate, flush, drain with prefetch
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_st_clear;
            r_clr_cnt    <= '0;
            r_flush_cnt  <= '0;
            r_acc_ready  <= 1'b0;
            r_dropped    <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_drain_done <= 1'b0;
            r_rd_val     <= '0;
            r_ptr        <= '0;
            r_rd_ch      <= '0;
            r_rd_h       <= '0;
            r_rd_w       <= '0;
        end else begin
            r_drain_done <= 1'b0;
            if (w_drop) begin
                r_dropped <= 1'b1;
            end

            case (r_state)
                c_st_clear: begin
                    if (r_clr_cnt == c_last) begin
                        r_clr_cnt   <= '0;
                        r_state     <= c_st_accum;
                        r_acc_ready <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end

                c_st_accum: begin
                    if (drain_start) begin
                        r_state     <= c_st_flush;
                        r_acc_ready <= 1'b0;
                        r_flush_cnt <= '0;
                    end
                end

                c_st_flush: begin
                    if ((r_flush_cnt == c_flush_last) && !r_s1_vld && !r_s2_vld) begin
                        // First entry is read here; memory already holds every commit
                        r_state    <= c_st_drain;
                        r_rd_valid <= 1'b1;
                        r_rd_val   <= r_mem[c_first];
                        r_rd_last  <= (c_depth == 1);
                        r_ptr      <= '0;
                        r_rd_ch    <= '0;
                        r_rd_h     <= '0;
                        r_rd_w     <= '0;
                    end else if (r_flush_cnt != c_flush_last) begin
                        r_flush_cnt <= r_flush_cnt + 2'd1;
                    end
                end

                c_st_drain: begin
                    if (w_rd_fire) begin
                        if (r_rd_last) begin
                            r_state      <= c_st_accum;
                            r_acc_ready  <= 1'b1;
                            r_drain_done <= 1'b1;
                            r_rd_valid   <= 1'b0;
                            r_rd_last    <= 1'b0;
                            r_rd_val     <= '0;
                            r_ptr        <= '0;
                            r_rd_ch      <= '0;
                            r_rd_h       <= '0;
                            r_rd_w       <= '0;
                        end else begin
                            // Next entry is fetched in the handshake cycle,
                            // so continuous ready sees no bubbles
                            r_ptr     <= w_ptr_nxt;
                            r_rd_val  <= r_mem[w_ptr_nxt];
                            r_rd_last <= (w_ptr_nxt == c_last);
                            if (32'(r_rd_w) == 32'(OUTPUT_WIDTH - 1)) begin
                                r_rd_w <= '0;
                                if (32'(r_rd_h) == 32'(OUTPUT_HEIGHT - 1)) begin
                                    r_rd_h  <= '0;
                                    r_rd_ch <= r_rd_ch + 1'b1;
                                end else begin
                                    r_rd_h <= r_rd_h + 1'b1;
                                end
                            end else begin
                                r_rd_w <= r_rd_w + 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    r_state     <= c_st_clear;
                    r_clr_cnt   <= '0;
                    r_acc_ready <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------
    assign acc_ready  = r_acc_ready;
    assign dropped    = r_dropped;
    assign rd_valid   = r_rd_valid;
    assign rd_channel = r_rd_ch;
    assign rd_height  = r_rd_h;
    assign rd_width   = r_rd_w;
    assign rd_val     = r_rd_val;
    assign rd_last    = r_rd_last;
    assign drain_done = r_drain_done;

endmodule

`default_nettype wire
